// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR unit: addresses, op encoding,
// mstatus bit positions and interrupt cause constants.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  typedef enum logic [1:0] {
    CSR_NONE = 2'b00,
    CSR_RW   = 2'b01,
    CSR_RS   = 2'b10,
    CSR_RC   = 2'b11
  } csr_op_e;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  // External line i reports cause code IRQ_CAUSE_OFFSET + i.
  localparam int          IRQ_CAUSE_OFFSET = 16;
  localparam logic [31:0] MCAUSE_INTR      = 32'h8000_0000;

  // Interrupt index width; covers up to 16 lines.
  localparam int IRQ_IDX_W = 4;

endpackage

// File: rtl/csr_irq_prio.sv
// Lowest-index-wins priority encoder over the pending interrupt vector.
module csr_irq_prio
  import csr_pkg::*;
#(
  parameter int NUM_IRQ = 4
) (
  input  logic [NUM_IRQ-1:0]   i_req,
  output logic                 o_any,
  output logic [IRQ_IDX_W-1:0] o_idx
);

  // Scan from the top down so the lowest set index is the last one to win.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise unassigned paths infer a latch.
    o_any = 1'b0;
    o_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_any = 1'b1;
        o_idx = IRQ_IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR block: RW/RS/RC access, prioritised interrupt entry,
// mret restore, direct/vectored mtvec and 64-bit cycle/instret counters.
module csr_unit
  import csr_pkg::*;
#(
  parameter int          NUM_IRQ     = 4,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0080
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         csr_op,
  input  logic [11:0]        csr_addr,
  input  logic [31:0]        csr_wdata,
  output logic [31:0]        csr_rdata,
  output logic               illegal_csr,
  input  logic [31:0]        pc_in,
  input  logic               is_mret,
  input  logic               instr_ret,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic               trap_taken,
  output logic               mret_taken,
  output logic [31:0]        redirect_pc
);

  csr_op_e w_op;
  assign w_op = csr_op_e'(csr_op);

  logic               r_mstatus_mie;
  logic               r_mstatus_mpie;
  logic [NUM_IRQ-1:0] r_mie;
  logic [NUM_IRQ-1:0] r_mip;
  logic [31:0]        r_mtvec;
  logic [31:0]        r_mepc;
  logic [31:0]        r_mcause;
  logic [63:0]        r_mcycle;
  logic [63:0]        r_minstret;

  logic [31:0] w_mstatus;
  logic [31:0] w_mie_full;
  logic [31:0] w_mip_full;
  assign w_mstatus  = (32'(r_mstatus_mie) << MSTATUS_MIE) | (32'(r_mstatus_mpie) << MSTATUS_MPIE);
  assign w_mie_full = 32'(r_mie) << IRQ_CAUSE_OFFSET;
  assign w_mip_full = 32'(r_mip) << IRQ_CAUSE_OFFSET;

  // Address decode: old value of the addressed CSR and whether it exists.
  logic        w_impl;
  logic [31:0] w_old;
  always_comb begin
    w_impl = 1'b1;
    w_old  = '0;
    case (csr_addr)
      CSR_MSTATUS:   w_old = w_mstatus;
      CSR_MIE:       w_old = w_mie_full;
      CSR_MTVEC:     w_old = r_mtvec;
      CSR_MEPC:      w_old = r_mepc;
      CSR_MCAUSE:    w_old = r_mcause;
      CSR_MIP:       w_old = w_mip_full;
      CSR_MCYCLE:    w_old = r_mcycle[31:0];
      CSR_MCYCLEH:   w_old = r_mcycle[63:32];
      CSR_MINSTRET:  w_old = r_minstret[31:0];
      CSR_MINSTRETH: w_old = r_minstret[63:32];
      default:       w_impl = 1'b0;
    endcase
  end

  assign csr_rdata   = (w_op != CSR_NONE && w_impl) ? w_old : '0;
  assign illegal_csr = (w_op != CSR_NONE) && !w_impl;

  // Value that the access would write back before masking.
  logic [31:0] w_new;
  always_comb begin
    w_new = w_old;
    case (w_op)
      CSR_RW:  w_new = csr_wdata;
      CSR_RS:  w_new = w_old | csr_wdata;
      CSR_RC:  w_new = w_old & ~csr_wdata;
      default: w_new = w_old;
    endcase
  end

  // Set/clear with a zero operand is a pure read.
  logic w_wr_req;
  logic w_wr_en;
  assign w_wr_req = (w_op != CSR_NONE) && w_impl &&
                    !((w_op == CSR_RS || w_op == CSR_RC) && csr_wdata == '0);

  logic                 w_any;
  logic [IRQ_IDX_W-1:0] w_idx;
  csr_irq_prio #(.NUM_IRQ(NUM_IRQ)) u_prio (
    .i_req (r_mip & r_mie),
    .o_any (w_any),
    .o_idx (w_idx)
  );

  logic [31:0] w_cause;
  logic [31:0] w_base;
  assign w_cause = 32'(IRQ_CAUSE_OFFSET) + 32'(w_idx);
  assign w_base  = {r_mtvec[31:2], 2'b00};

  assign trap_taken  = !rst && r_mstatus_mie && w_any && !is_mret;
  assign mret_taken  = is_mret;
  assign redirect_pc = is_mret    ? r_mepc :
                       r_mtvec[0] ? w_base + (w_cause << 2) : w_base;

  // mret and trap entry both pre-empt a software write in the same cycle.
  assign w_wr_en = w_wr_req && !is_mret && !trap_taken;

  // Trap/mret/software updates of the control CSRs and mip sampling.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie          <= '0;
      r_mip          <= '0;
      r_mtvec        <= MTVEC_RESET;
      r_mepc         <= '0;
      r_mcause       <= '0;
    end else begin
      // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
      r_mip <= irq_i;
      if (is_mret) begin
        r_mstatus_mie  <= r_mstatus_mpie;
        r_mstatus_mpie <= 1'b1;
      end else if (trap_taken) begin
        r_mepc         <= pc_in & ~32'h3;
        r_mcause       <= MCAUSE_INTR | w_cause;
        r_mstatus_mpie <= r_mstatus_mie;
        r_mstatus_mie  <= 1'b0;
      end else if (w_wr_en) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            r_mstatus_mie  <= w_new[MSTATUS_MIE];
            r_mstatus_mpie <= w_new[MSTATUS_MPIE];
          end
          CSR_MIE:    r_mie    <= w_new[IRQ_CAUSE_OFFSET +: NUM_IRQ];
          CSR_MTVEC:  r_mtvec  <= w_new & ~32'h2;
          CSR_MEPC:   r_mepc   <= w_new & ~32'h3;
          CSR_MCAUSE: r_mcause <= w_new;
          default:    ;
        endcase
      end
    end
  end

  // Free-running counters; a half write replaces that half and kills its increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcycle   <= '0;
      r_minstret <= '0;
    end else begin
      r_mcycle   <= r_mcycle + 64'd1;
      r_minstret <= r_minstret + 64'(instr_ret);
      if (w_wr_en) begin
        case (csr_addr)
          CSR_MCYCLE:    r_mcycle   <= {r_mcycle[63:32], w_new};
          CSR_MCYCLEH:   r_mcycle[63:32] <= w_new;
          CSR_MINSTRET:  r_minstret <= {r_minstret[63:32], w_new};
          CSR_MINSTRETH: r_minstret[63:32] <= w_new;
          default:       ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_csr_unit;

  localparam int NUM_IRQ = 4;

  logic               clk;
  logic               rst;
  logic [1:0]         csr_op;
  logic [11:0]        csr_addr;
  logic [31:0]        csr_wdata;
  logic [31:0]        csr_rdata;
  logic               illegal_csr;
  logic [31:0]        pc_in;
  logic               is_mret;
  logic               instr_ret;
  logic [NUM_IRQ-1:0] irq_i;
  logic               trap_taken;
  logic               mret_taken;
  logic [31:0]        redirect_pc;

  csr_unit #(.NUM_IRQ(NUM_IRQ), .MTVEC_RESET(32'h0000_0080)) dut (
    .clk         (clk),
    .rst         (rst),
    .csr_op      (csr_op),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .csr_rdata   (csr_rdata),
    .illegal_csr (illegal_csr),
    .pc_in       (pc_in),
    .is_mret     (is_mret),
    .instr_ret   (instr_ret),
    .irq_i       (irq_i),
    .trap_taken  (trap_taken),
    .mret_taken  (mret_taken),
    .redirect_pc (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (architectural CSR values) ----------
  logic [31:0] m_mstatus, m_mie, m_mip, m_mtvec, m_mepc, m_mcause;
  logic [63:0] m_cyc, m_ins;
  bit          m_valid = 0;

  localparam logic [31:0] MIE_MASK = ((32'd1 << NUM_IRQ) - 32'd1) << 16;

  function automatic logic [31:0] m_read(input logic [11:0] a, output bit impl);
    impl = 1;
    case (a)
      12'h300: return m_mstatus;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return m_mip;
      12'hB00: return m_cyc[31:0];
      12'hB80: return m_cyc[63:32];
      12'hB02: return m_ins[31:0];
      12'hB82: return m_ins[63:32];
      default: begin impl = 0; return 32'h0; end
    endcase
  endfunction

  // Writable-bit mask for each CSR; mip is read-only.
  function automatic logic [31:0] m_mask(input logic [11:0] a);
    case (a)
      12'h300: return 32'h0000_0088;
      12'h304: return MIE_MASK;
      12'h305: return 32'hFFFF_FFFD;
      12'h341: return 32'hFFFF_FFFC;
      12'h344: return 32'h0;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Compare process: expected outputs from model state + current inputs,
  // then advance the model to what the next edge must produce.
  always @(negedge clk) begin
    bit          impl, wr, trap;
    logic [31:0] old, nv, pend, cause, base, exp_pc;
    int          idx;
    old  = m_read(csr_addr, impl);
    pend = m_mip & m_mie;
    idx  = -1;
    for (int i = 0; i < NUM_IRQ; i++)
      if (pend[16+i] && idx < 0) idx = i;
    cause = 32'(16 + idx);
    trap  = !rst && m_valid && m_mstatus[3] && (pend != 0) && !is_mret;
    if (m_valid || rst) begin
      check("trap_taken", {31'b0, trap_taken}, {31'b0, trap});
      check("mret_taken", {31'b0, mret_taken}, {31'b0, is_mret});
    end
    if (m_valid && !rst) begin
      check("csr_rdata", csr_rdata, (csr_op != 2'b00 && impl) ? old : 32'h0);
      check("illegal_csr", {31'b0, illegal_csr}, {31'b0, csr_op != 2'b00 && !impl});
      base   = m_mtvec & ~32'h3;
      exp_pc = is_mret ? m_mepc : (m_mtvec[0] ? base + 4 * cause : base);
      if (is_mret || trap) check("redirect_pc", redirect_pc, exp_pc);
    end
    if (rst) begin
      m_mstatus = 0; m_mie = 0; m_mip = 0; m_mtvec = 32'h80;
      m_mepc = 0; m_mcause = 0; m_cyc = 0; m_ins = 0;
      m_valid = 1;
    end else if (m_valid) begin
      case (csr_op)
        2'b01:   nv = csr_wdata;
        2'b10:   nv = old | csr_wdata;
        2'b11:   nv = old & ~csr_wdata;
        default: nv = old;
      endcase
      nv = (old & ~m_mask(csr_addr)) | (nv & m_mask(csr_addr));
      wr = csr_op != 2'b00 && impl && !(csr_op[1] && csr_wdata == 0) && !is_mret && !trap;
      m_mip = 32'(irq_i) << 16;
      if (wr && csr_addr == 12'hB00)      m_cyc = {m_cyc[63:32], nv};
      else if (wr && csr_addr == 12'hB80) m_cyc = {nv, m_cyc[31:0] + 32'd1};
      else                                m_cyc = m_cyc + 1;
      if (wr && csr_addr == 12'hB02)      m_ins = {m_ins[63:32], nv};
      else if (wr && csr_addr == 12'hB82) m_ins = {nv, m_ins[31:0] + 32'(instr_ret)};
      else                                m_ins = m_ins + 64'(instr_ret);
      if (is_mret) begin
        m_mstatus = 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
      end else if (trap) begin
        m_mepc    = pc_in & ~32'h3;
        m_mcause  = 32'h8000_0000 | cause;
        m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
      end else if (wr) begin
        case (csr_addr)
          12'h300: m_mstatus = nv;
          12'h304: m_mie     = nv;
          12'h305: m_mtvec   = nv;
          12'h341: m_mepc    = nv;
          12'h342: m_mcause  = nv;
          default: ;
        endcase
      end
    end
  end

  // ---------------- stimulus helpers ---------------------------------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string nm);
    csr_op = 2'b10; csr_addr = a; csr_wdata = 32'h0;
    @(negedge clk);
    check(nm, csr_rdata, exp);
    next_cycle();
    csr_op = 2'b00;
  endtask

  task automatic wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
    csr_op = op; csr_addr = a; csr_wdata = d;
    next_cycle();
    csr_op = 2'b00; csr_wdata = 32'h0;
  endtask

  logic [11:0] addrs [12] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344,
                              12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h7C0, 12'h301};

  initial begin
    rst = 1; csr_op = 0; csr_addr = 0; csr_wdata = 0; pc_in = 0;
    is_mret = 0; instr_ret = 0; irq_i = 0;

    // Reset: trap suppressed, mret_taken follows is_mret.
    @(negedge clk);
    check("rst_trap", {31'b0, trap_taken}, 32'h0);
    next_cycle();
    is_mret = 1;
    @(negedge clk);
    check("rst_mret", {31'b0, mret_taken}, 32'h1);
    next_cycle();
    rst = 0; is_mret = 0;

    // Reset values.
    rd(12'hB00, 32'h0,  "rv_mcycle");
    rd(12'h300, 32'h0,  "rv_mstatus");
    rd(12'h304, 32'h0,  "rv_mie");
    rd(12'h305, 32'h80, "rv_mtvec");
    rd(12'h341, 32'h0,  "rv_mepc");
    rd(12'h342, 32'h0,  "rv_mcause");
    rd(12'h344, 32'h0,  "rv_mip");
    rd(12'hB80, 32'h0,  "rv_mcycleh");
    rd(12'hB02, 32'h0,  "rv_minstret");
    rd(12'hB82, 32'h0,  "rv_minstreth");
    csr_op = 2'b10; csr_addr = 12'h7C0;
    @(negedge clk);
    check("illegal_flag", {31'b0, illegal_csr}, 32'h1);
    check("illegal_rdata", csr_rdata, 32'h0);
    next_cycle();
    csr_op = 2'b00; csr_addr = 12'h305;
    @(negedge clk);
    check("noop_rdata", csr_rdata, 32'h0);
    next_cycle();

    // Masking and set/clear.
    wr(2'b01, 12'h300, 32'hFFFF_FFFF);
    rd(12'h300, 32'h88, "mstatus_mask");
    wr(2'b11, 12'h300, 32'h8);
    rd(12'h300, 32'h80, "mstatus_rc");
    rd(12'h300, 32'h80, "rs_zero_noop");

    // Vectored trap.
    wr(2'b01, 12'h305, 32'h101);
    wr(2'b01, 12'h304, 32'h3_0000);
    wr(2'b01, 12'h300, 32'h8);
    irq_i = 4'b0011; pc_in = 32'h200;
    @(negedge clk);
    check("irq_latency", {31'b0, trap_taken}, 32'h0);
    next_cycle();
    @(negedge clk);
    check("trap_taken", {31'b0, trap_taken}, 32'h1);
    check("trap_vector", redirect_pc, 32'h140);
    next_cycle();
    rd(12'h342, 32'h8000_0010, "trap_mcause");
    rd(12'h341, 32'h200, "trap_mepc");
    rd(12'h300, 32'h80, "trap_mstatus");

    // mret restore and re-fire.
    is_mret = 1;
    @(negedge clk);
    check("mret_taken", {31'b0, mret_taken}, 32'h1);
    check("mret_target", redirect_pc, 32'h200);
    check("mret_no_trap", {31'b0, trap_taken}, 32'h0);
    next_cycle();
    is_mret = 0;
    csr_op = 2'b10; csr_addr = 12'h300; csr_wdata = 0;
    @(negedge clk);
    check("mret_mstatus", csr_rdata, 32'h88);
    check("refire", {31'b0, trap_taken}, 32'h1);
    next_cycle();

    // Write-enable visibility, then trap/write collision on mepc.
    csr_op = 2'b01; csr_addr = 12'h300; csr_wdata = 32'h8;
    @(negedge clk);
    check("wr_vis", {31'b0, trap_taken}, 32'h0);
    next_cycle();
    csr_op = 2'b01; csr_addr = 12'h341; csr_wdata = 32'h1234; pc_in = 32'h300;
    @(negedge clk);
    check("coll_trap", {31'b0, trap_taken}, 32'h1);
    check("coll_rdata", csr_rdata, 32'h200);
    next_cycle();
    csr_op = 2'b00;
    rd(12'h341, 32'h300, "coll_mepc");
    irq_i = 0;
    wr(2'b01, 12'h304, 32'h0);

    // Counter carry and write priority.
    wr(2'b01, 12'hB80, 32'h0);
    wr(2'b01, 12'hB00, 32'hFFFF_FFFF);
    next_cycle();
    rd(12'hB80, 32'h1, "mcycle_carry");
    instr_ret = 1;
    wr(2'b01, 12'hB02, 32'h55);
    instr_ret = 0;
    rd(12'hB02, 32'h55, "minstret_wr_wins");

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      rst       = ($urandom_range(0, 299) == 0);
      csr_op    = 2'($urandom_range(0, 3));
      csr_addr  = addrs[$urandom_range(0, 11)];
      case ($urandom_range(0, 3))
        0:       csr_wdata = 32'h0;
        1:       csr_wdata = 32'hFFFF_FFFF;
        default: csr_wdata = $urandom;
      endcase
      is_mret   = ($urandom_range(0, 15) == 0);
      instr_ret = 1'($urandom_range(0, 1));
      pc_in     = $urandom & ~32'h3;
      if ($urandom_range(0, 7) == 0) irq_i = NUM_IRQ'($urandom);
      next_cycle();
    end
    rst = 0; csr_op = 0; is_mret = 0;
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
